// File: rtl/can_crc_check.sv
// CAN receive-side CRC checker: runs CRC-15/17/21 in parallel over the covered
// bits, captures the received CRC sequence and flags a mismatch at its end.
module can_crc_check (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        sample_point,
  input  logic        rx_bit,
  input  logic        data_en,
  input  logic        crc_field_en,
  input  logic        fd_mode,
  input  logic        crc21_sel,
  output logic [20:0] crc_calc,
  output logic [20:0] crc_recv,
  output logic        crc_done,
  output logic        crc_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [14:0] POLY15 = 15'h4599;
  localparam logic [16:0] POLY17 = 17'h1685B;
  localparam logic [20:0] POLY21 = 21'h102899;
  localparam logic [16:0] INIT17 = 17'h10000;
  localparam logic [20:0] INIT21 = 21'h100000;
  localparam logic [4:0]  LEN15  = 5'd15;
  localparam logic [4:0]  LEN17  = 5'd17;
  localparam logic [4:0]  LEN21  = 5'd21;

  state_t      r_state;
  state_t      w_next_state;
  logic [14:0] r_crc15;
  logic [16:0] r_crc17;
  logic [20:0] r_crc21;
  logic [20:0] r_recv;
  logic [4:0]  r_cnt;
  logic [4:0]  r_len;
  logic        r_err;
  logic        r_done;

  logic [14:0] w_crc15_nxt;
  logic [16:0] w_crc17_nxt;
  logic [20:0] w_crc21_nxt;
  logic [4:0]  w_len_live;
  logic [4:0]  w_len_sel;
  logic [20:0] w_calc_sel;
  logic [20:0] w_recv_next;
  logic [20:0] w_mask;
  logic [4:0]  w_cnt_next;
  logic        w_data_upd;
  logic        w_field_first;
  logic        w_field_recv;
  logic        w_last;

  // A field bit wins over a data bit when both enables are set, so the
  // calculators are frozen from the first CRC bit onward.
  assign w_data_upd    = (r_state == CALC) && sample_point && data_en && !crc_field_en;
  assign w_field_first = (r_state == CALC) && sample_point && crc_field_en;
  assign w_field_recv  = (r_state == RECV) && sample_point && crc_field_en;

  assign w_crc15_nxt = {r_crc15[13:0], 1'b0} ^ ((rx_bit ^ r_crc15[14]) ? POLY15 : 15'd0);
  assign w_crc17_nxt = {r_crc17[15:0], 1'b0} ^ ((rx_bit ^ r_crc17[16]) ? POLY17 : 17'd0);
  assign w_crc21_nxt = {r_crc21[19:0], 1'b0} ^ ((rx_bit ^ r_crc21[20]) ? POLY21 : 21'd0);

  assign w_recv_next = {r_recv[19:0], rx_bit};
  assign w_cnt_next  = (r_cnt == 5'd31) ? r_cnt : r_cnt + 5'd1;
  assign w_mask      = (21'd1 << r_len) - 21'd1;
  assign w_last      = w_field_recv && (w_cnt_next == r_len);

  // NOTE: every signal written in an always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_len_live = LEN21;
    if (!fd_mode)        w_len_live = LEN15;
    else if (!crc21_sel) w_len_live = LEN17;

    // The latched length only means something once the CRC field has started.
    w_len_sel = ((r_state == RECV) || (r_state == DONE)) ? r_len : w_len_live;

    w_calc_sel = r_crc21;
    case (w_len_sel)
      LEN15:   w_calc_sel = {6'd0, r_crc15};
      LEN17:   w_calc_sel = {4'd0, r_crc17};
      default: w_calc_sel = r_crc21;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    if (init) begin
      w_next_state = CALC;
    end else begin
      case (r_state)
        CALC:    if (w_field_first) w_next_state = RECV;
        RECV:    if (w_last)        w_next_state = DONE;
        default: w_next_state = r_state;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc15 <= '0;
      r_crc17 <= '0;
      r_crc21 <= '0;
      r_recv  <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else if (init) begin
      r_crc15 <= '0;
      r_crc17 <= INIT17;
      r_crc21 <= INIT21;
      r_recv  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_data_upd) begin
        r_crc15 <= w_crc15_nxt;
        r_crc17 <= w_crc17_nxt;
        r_crc21 <= w_crc21_nxt;
      end
      if (w_field_first) begin
        r_len  <= w_len_live;
        r_recv <= w_recv_next;
        r_cnt  <= w_cnt_next;
      end
      if (w_field_recv) begin
        r_recv <= w_recv_next;
        r_cnt  <= w_cnt_next;
      end
      // Compare against the value that includes the bit arriving right now.
      if (w_last) begin
        r_err  <= ((w_recv_next & w_mask) != w_calc_sel);
        r_done <= 1'b1;
      end
    end
  end

  assign crc_calc = w_calc_sel;
  assign crc_recv = r_recv;
  assign crc_done = r_done;
  assign crc_err  = r_err;
  assign busy     = (r_state == CALC) || (r_state == RECV);

endmodule
